bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Sequences ownership of the shared 8-bit data bus `data_bus` inside cpu8bit.
- Its requesters are the operation unit, data memory, an external I/O port and a spare.
- Grants one requester at a time using round-robin priority and enforces a maximum hold time (unless the owner locks the bus).
- Inserts a turnaround gap between owners so that no two tri-state drivers overlap.
- The control unit raises `req_i` bits in place of driving `OU_write`/`DM_read` straight onto the bus; each unit's bus-drive enable comes from `drive_en_o`.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_HOLD, 8, cycles an unlocked owner may keep the bus (1..15).
- TURN_CYC, 1, idle bus cycles between owners (1..3).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- req_i  in  N_REQ  per-requester bus request; level, held until finished.
- lock_i  in  N_REQ  per-requester lock; honoured only for the current owner.
- grant_o  out  N_REQ  one-hot grant; all-zero when no owner.
- drive_en_o  out  N_REQ  tri-state drive enable; equals grant_o (registered).
- owner_o  out  OW  index of current or last owner; OW = max(1, clog2(N_REQ)).
- busy_o  out  1  high while a grant is active.
- timeout_o  out  1  one-cycle pulse when an owner is forcibly released.

Behaviour:
- Reset (rst_i=0 at a rising edge) forces:
  - state=IDLE; grant_o=0, drive_en_o=0, busy_o=0, timeout_o=0, owner_o=0.
  - Round-robin pointer set so requester 0 has highest priority; hold counter=0.
- Reset applied mid-grant drops grant_o/drive_en_o at that edge with no turnaround; the bus floats.
- All outputs are registered.
- FSM states: IDLE, GRANT, TURN.
- IDLE:
  - If any req_i bit is set, pick the first set bit at or after pointer, wrapping modulo N_REQ.
  - At the next edge: state=GRANT, grant_o/drive_en_o=one-hot(pick), owner_o=pick, busy_o=1, hold=1.
  - Pointer becomes (pick+1) mod N_REQ.
  - Request-to-grant latency: 1 cycle.
- GRANT, evaluated at each edge in this order:
  - (a) req_i[owner]=0: go to TURN. Grant and busy drop at this edge.
  - (b) else if lock_i[owner]=1: stay in GRANT; hold saturates at MAX_HOLD.
  - (c) else if hold==MAX_HOLD: go to TURN and pulse timeout_o=1 for one cycle.
  - (d) else: stay; hold+1.
- Lock:
  - lock_i of non-owners is ignored.
  - When lock deasserts after saturation, release occurs at the next edge via (c).
- TURN:
  - grant_o=0 for exactly TURN_CYC cycles.
  - In the final TURN cycle, arbitrate as in IDLE. The grant asserts at the following edge; otherwise go to IDLE.
  - Minimum owner-to-owner gap on drive_en_o: TURN_CYC cycles.
- A preempted owner still requesting is last in priority at the next pick (pointer already advanced past it).
- Requests arriving during GRANT/TURN wait; they are never dropped, since req_i is a level.
- Simultaneous requests: the requester closest after pointer wins; all others keep waiting.
- Owner whose request drops in the same cycle another requester rises: normal release, then turnaround, then the new grant.
- owner_o holds the last owner while in IDLE/TURN.
- Invariant: popcount(grant_o) ≤ 1 always; drive_en_o == grant_o.

Decomposition:
- Package cpu8bit_bus_pkg holds:
  - state enum {IDLE, GRANT, TURN};
  - default constants N_REQ_DEF=4, MAX_HOLD_DEF=8, TURN_CYC_DEF=1;
  - requester index constants REQ_OU=0, REQ_DM=1, REQ_IO=2, REQ_SPARE=3.
- One sub-module: rr_priority_pick. It is combinational, with inputs req and pointer and outputs valid and index; it is reused by the FSM in IDLE and in the final TURN cycle.

Test Plan:
- Reset: hold rst_i=0 two cycles with req_i=4'b1111 → grant_o=0, busy_o=0, owner_o=0. Release reset → grant_o=0001 one cycle later.
- Round-robin: req_i=4'b1111 held constant, each owner drops its req 3 cycles after grant and re-raises 1 cycle later → grant order 0,1,2,3,0. There is a 1-cycle all-zero gap between grants; popcount never exceeds 1.
- Timeout: req_i=4'b0011 held, no lock → owner 0 granted for exactly 8 cycles. timeout_o pulses at release; after the 1-cycle turnaround grant_o=0010.
- Lock: owner 2 with lock_i[2]=1 for 20 cycles while req_i[0]=1 → grant_o stays 0100 for 20 cycles with no timeout. On lock drop, release at the next edge with timeout_o=1, then grant_o=0001.
- Reset mid-grant: rst_i=0 in the 4th grant cycle of owner 1 → grant_o=0 and drive_en_o=0 at that edge; after release, requester 0 has priority.
- TURN_CYC=3 build: back-to-back requesters 1 and 3 → exactly 3 all-zero cycles between drive_en_o=0010 and 1000.

Source files
------------

// File: rtl/cpu8bit_bus_pkg.sv
// Shared types and constants for the cpu8bit data-bus arbiter.
package cpu8bit_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  localparam int N_REQ_DEF    = 4;
  localparam int MAX_HOLD_DEF = 8;
  localparam int TURN_CYC_DEF = 1;

  localparam int REQ_OU    = 0;
  localparam int REQ_DM    = 1;
  localparam int REQ_IO    = 2;
  localparam int REQ_SPARE = 3;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request at or after pointer, wrapping.
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int OW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    pointer,
  output logic             valid,
  output logic [OW-1:0]    index
);

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    int j;
    valid = 1'b0;
    index = '0;
    j     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(pointer) + i) % N_REQ;
      if (!valid && req[j]) begin
        valid = 1'b1;
        index = OW'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner sequencing for the shared 8-bit data bus, with hold
// timeout, owner lock and a tri-state turnaround gap between owners.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner, bus floats; arbitrate every cycle
// GRANT | one requester drives the bus; hold counter running
// TURN  | bus floats for TURN_CYC cycles; arbitrate in the last one
module bus_arbiter
  import cpu8bit_bus_pkg::*;
#(
  parameter  int N_REQ    = N_REQ_DEF,
  parameter  int MAX_HOLD = MAX_HOLD_DEF,
  parameter  int TURN_CYC = TURN_CYC_DEF,
  localparam int OW       = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] lock_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [N_REQ-1:0] drive_en_o,
  output logic [OW-1:0]    owner_o,
  output logic             busy_o,
  output logic             timeout_o
);

  localparam logic [3:0]       HOLD_MAX   = 4'(MAX_HOLD);
  localparam logic [1:0]       TURN_START = 2'(TURN_CYC - 1);
  localparam logic [OW-1:0]    LAST_IDX   = OW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0   = N_REQ'(1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [3:0]       hold_q, hold_d;
  logic [1:0]       turn_q, turn_d;
  logic             pick_valid;
  logic [OW-1:0]    pick_idx;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .OW    (OW)
  ) u_pick (
    .req     (req_i),
    .pointer (ptr_q),
    .valid   (pick_valid),
    .index   (pick_idx)
  );

  // Next-state and next-output decode; every output is taken from a flop.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    turn_d    = turn_q;
    case (state_q)
      IDLE, TURN: begin
        if (state_q == TURN && turn_q != 2'd0) begin
          turn_d = turn_q - 2'd1;
        end else if (pick_valid) begin
          state_d = GRANT;
          grant_d = ONE_HOT0 << pick_idx;
          owner_d = pick_idx;
          ptr_d   = (pick_idx == LAST_IDX) ? '0 : pick_idx + OW'(1);
          busy_d  = 1'b1;
          hold_d  = 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!req_i[owner_q]) begin
          state_d = TURN;
          grant_d = '0;
          busy_d  = 1'b0;
          hold_d  = 4'd0;
          turn_d  = TURN_START;
        end else if (lock_i[owner_q]) begin
          if (hold_q != HOLD_MAX) hold_d = hold_q + 4'd1;
        end else if (hold_q == HOLD_MAX) begin
          state_d   = TURN;
          grant_d   = '0;
          busy_d    = 1'b0;
          hold_d    = 4'd0;
          turn_d    = TURN_START;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the grant immediately.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= 4'd0;
      turn_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
      turn_q    <= turn_d;
    end
  end

  assign grant_o    = grant_q;
  assign drive_en_o = grant_q;
  assign owner_o    = owner_q;
  assign busy_o     = busy_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: default build plus a TURN_CYC=3 build.
module tb_bus_arbiter;

  typedef struct packed {
    logic [3:0] grant;
    logic       timeout;
    logic [1:0] owner;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [3:0] req_i = '0;
  logic [3:0] lock_i = '0;
  logic [3:0] grant_o, drive_en_o;
  logic [1:0] owner_o;
  logic       busy_o, timeout_o;

  logic       rst3 = 1'b0;
  logic [3:0] req3 = '0;
  logic [3:0] lock3 = '0;
  logic [3:0] grant3, drive3;
  logic [1:0] owner3;
  logic       busy3, timeout3;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];
  int   own_q[$];

  always #5 clk_i = ~clk_i;

  bus_arbiter dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .lock_i     (lock_i),
    .grant_o    (grant_o),
    .drive_en_o (drive_en_o),
    .owner_o    (owner_o),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o)
  );

  bus_arbiter #(.N_REQ(4), .MAX_HOLD(8), .TURN_CYC(3)) dut3 (
    .clk_i      (clk_i),
    .rst_i      (rst3),
    .req_i      (req3),
    .lock_i     (lock3),
    .grant_o    (grant3),
    .drive_en_o (drive3),
    .owner_o    (owner3),
    .busy_o     (busy3),
    .timeout_o  (timeout3)
  );

  task automatic do_reset(input logic [3:0] r);
    rst_i  = 1'b0;
    req_i  = r;
    lock_i = '0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_reset();
    do_reset(4'b1111);
    n_checks++;
    if (grant_o !== 4'b0000 || drive_en_o !== 4'b0000 || busy_o !== 1'b0 ||
        owner_o !== 2'd0 || timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: grant=%b drive=%b busy=%b owner=%0d timeout=%b, want all zero",
               grant_o, drive_en_o, busy_o, owner_o, timeout_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (grant_o !== 4'b0001 || drive_en_o !== 4'b0001 || busy_o !== 1'b1 || owner_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_release: grant=%b drive=%b busy=%b owner=%0d, want grant=0001 busy=1 owner=0",
               grant_o, drive_en_o, busy_o, owner_o);
    end
  endtask

  task automatic test_round_robin();
    int gcnt[4];
    int rr[4];
    int zeros;
    int budget;
    int exp_idx;
    bit seen;
    logic [3:0] prev;
    do_reset(4'b1111);
    own_q.delete();
    foreach (gcnt[i]) begin gcnt[i] = 0; rr[i] = 0; end
    own_q.push_back(0); own_q.push_back(1); own_q.push_back(2);
    own_q.push_back(3); own_q.push_back(0);
    rst_i  = 1'b1;
    prev   = '0;
    zeros  = 0;
    seen   = 1'b0;
    budget = 0;
    while (own_q.size() > 0 && budget < 80) begin
      @(negedge clk_i);
      budget++;
      n_checks++;
      if ($countones(grant_o) > 1 || drive_en_o !== grant_o) begin
        n_fail++;
        $display("FAIL rr_invariant: grant=%b drive=%b, want one-hot-or-zero and equal", grant_o, drive_en_o);
      end
      if (grant_o != 4'b0000 && prev == 4'b0000) begin
        exp_idx = own_q.pop_front();
        n_checks++;
        if (grant_o !== (4'b0001 << exp_idx) || owner_o !== 2'(exp_idx)) begin
          n_fail++;
          $display("FAIL rr_order: grant=%b owner=%0d, want owner %0d", grant_o, owner_o, exp_idx);
        end
        if (seen) begin
          n_checks++;
          if (zeros != 1) begin
            n_fail++;
            $display("FAIL rr_gap: gap=%0d cycles, want 1", zeros);
          end
        end
        seen  = 1'b1;
        zeros = 0;
      end else if (grant_o == 4'b0000 && seen) begin
        zeros++;
      end
      for (int i = 0; i < 4; i++) begin
        if (rr[i] > 0) begin
          rr[i]--;
          if (rr[i] == 0) req_i[i] = 1'b1;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (grant_o[i]) begin
          gcnt[i]++;
          if (gcnt[i] == 3) begin
            req_i[i] = 1'b0;
            rr[i]    = 1;
            gcnt[i]  = 0;
          end
        end
      end
      prev = grant_o;
    end
    n_checks++;
    if (own_q.size() != 0) begin
      n_fail++;
      $display("FAIL rr_budget: %0d grants still pending, want 0", own_q.size());
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int k;
    do_reset(4'b0011);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back('{4'b0001, 1'b0, 2'd0});
    exp_q.push_back('{4'b0000, 1'b1, 2'd0});
    exp_q.push_back('{4'b0010, 1'b0, 2'd1});
    rst_i = 1'b1;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk_i);
      k++;
      e = exp_q.pop_front();
      n_checks++;
      if (grant_o !== e.grant || drive_en_o !== e.grant || timeout_o !== e.timeout ||
          owner_o !== e.owner || busy_o !== (e.grant != 4'b0000)) begin
        n_fail++;
        $display("FAIL timeout cyc%0d: grant=%b drive=%b timeout=%b owner=%0d busy=%b, want grant=%b timeout=%b owner=%0d",
                 k, grant_o, drive_en_o, timeout_o, owner_o, busy_o, e.grant, e.timeout, e.owner);
      end
    end
  endtask

  task automatic test_lock();
    exp_t e;
    int k;
    do_reset(4'b0100);
    lock_i = 4'b0100;
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back('{4'b0100, 1'b0, 2'd2});
    exp_q.push_back('{4'b0000, 1'b1, 2'd2});
    exp_q.push_back('{4'b0001, 1'b0, 2'd0});
    rst_i = 1'b1;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk_i);
      k++;
      e = exp_q.pop_front();
      n_checks++;
      if (grant_o !== e.grant || drive_en_o !== e.grant || timeout_o !== e.timeout || owner_o !== e.owner) begin
        n_fail++;
        $display("FAIL lock cyc%0d: grant=%b drive=%b timeout=%b owner=%0d, want grant=%b timeout=%b owner=%0d",
                 k, grant_o, drive_en_o, timeout_o, owner_o, e.grant, e.timeout, e.owner);
      end
      if (k == 1) req_i = 4'b0101;
      if (k == 20) lock_i = 4'b0000;
    end
  endtask

  task automatic test_reset_mid_grant();
    exp_t e;
    int k;
    do_reset(4'b0010);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back('{4'b0010, 1'b0, 2'd1});
    exp_q.push_back('{4'b0000, 1'b0, 2'd0});
    exp_q.push_back('{4'b0001, 1'b0, 2'd0});
    rst_i = 1'b1;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk_i);
      k++;
      e = exp_q.pop_front();
      n_checks++;
      if (grant_o !== e.grant || drive_en_o !== e.grant || owner_o !== e.owner ||
          busy_o !== (e.grant != 4'b0000)) begin
        n_fail++;
        $display("FAIL reset_mid cyc%0d: grant=%b drive=%b owner=%0d busy=%b, want grant=%b owner=%0d",
                 k, grant_o, drive_en_o, owner_o, busy_o, e.grant, e.owner);
      end
      if (k == 4) rst_i = 1'b0;
      if (k == 5) begin
        rst_i = 1'b1;
        req_i = 4'b1111;
      end
    end
  endtask

  task automatic test_turn3();
    exp_t e;
    int k;
    rst3 = 1'b0;
    req3 = 4'b1010;
    @(negedge clk_i);
    exp_q.delete();
    exp_q.push_back('{4'b0010, 1'b0, 2'd1});
    exp_q.push_back('{4'b0010, 1'b0, 2'd1});
    for (int i = 0; i < 3; i++) exp_q.push_back('{4'b0000, 1'b0, 2'd1});
    exp_q.push_back('{4'b1000, 1'b0, 2'd3});
    rst3 = 1'b1;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk_i);
      k++;
      e = exp_q.pop_front();
      n_checks++;
      if (drive3 !== e.grant || grant3 !== e.grant || owner3 !== e.owner || timeout3 !== e.timeout) begin
        n_fail++;
        $display("FAIL turn3 cyc%0d: drive=%b grant=%b owner=%0d timeout=%b, want drive=%b owner=%0d",
                 k, drive3, grant3, owner3, timeout3, e.grant, e.owner);
      end
      if (k == 2) req3 = 4'b1000;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_timeout();
    test_lock();
    test_reset_mid_grant();
    test_turn3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
